fetch_prefetch_queue: RTL
=========================

Name: fetch_prefetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the pipelined datapath.
- Generates sequential fetch addresses and issues them to instruction memory over a valid/ready request channel, with in-order responses.
- Buffers returned words with their PCs in a small queue and presents {instr, instr_pc} to the Fetch→Decode register with a valid/ready handshake.
- Handles taken-branch/PC-write redirects by flushing the queue and discarding in-flight responses.

Parameters:
- DEPTH, 4, queue entries (power of 2, ≥2).
- MAX_OUTSTANDING, 2, maximum requests issued but not yet responded (≥1).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = in reset.
- ireq_valid  out  1  fetch request valid.
- ireq_addr  out  32  fetch address, word-aligned.
- ireq_ready  in  1  memory accepts the request this cycle.
- iresp_valid  in  1  response word valid; responses arrive in request order, ≥1 cycle after acceptance.
- iresp_data  in  32  instruction word.
- instr_valid  out  1  queue head valid toward decode.
- instr  out  32  instruction word at queue head.
- instr_pc  out  32  PC of instr.
- instr_ready  in  1  decode consumes head (inverse of StallD).
- redirect  in  1  PC redirect (branch / PC write from writeback).
- redirect_pc  in  32  new fetch address; bits [1:0] ignored, forced to 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - fetch_pc = RESET_PC; resp_pc = RESET_PC.
  - Queue empty; outstanding = 0; drop_cnt = 0.
  - Outputs: ireq_valid=0, ireq_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
  - First request is presented the first cycle after reset deasserts.
- Credit rule:
  - ireq_valid = !redirect && (outstanding < MAX_OUTSTANDING) && (count + outstanding - drop_cnt < DEPTH).
  - A response therefore never finds the queue full, and no response is ever dropped for lack of space.
- Request handshake:
  - A request is accepted when ireq_valid && ireq_ready; on acceptance fetch_pc += 4 (wraps mod 2^32) and outstanding++.
  - ireq_addr = fetch_pc and stays stable while ireq_valid && !ireq_ready.
- Response path:
  - Each iresp_valid decrements outstanding.
  - If drop_cnt > 0: the word is discarded and drop_cnt--.
  - Otherwise {resp_pc, iresp_data} is written at the queue tail and resp_pc += 4.
  - Queue-to-output latency is 1 cycle: an entry written at edge N is visible at instr/instr_valid after edge N.
- Output handshake:
  - instr_valid = (count != 0). The head is popped on instr_valid && instr_ready.
  - instr and instr_pc hold stable while instr_valid && !instr_ready.
  - When the queue is empty, instr and instr_pc hold their last values.
- Simultaneous push and pop: count is unchanged. Push on full cannot occur (credit rule); pop on empty is ignored.
- Redirect (sampled at the clock edge):
  - Queue flushed to count = 0; instr_valid is 0 the following cycle.
  - fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}.
  - drop_cnt = outstanding-after-this-cycle: existing outstanding, plus any request accepted this cycle (none, since ireq_valid is forced low), minus a response arriving this cycle.
  - A response arriving in the redirect cycle is discarded.
  - The first request to the new PC is issued the cycle after redirect.
  - Back-to-back redirects: the last one wins, and drop_cnt is recomputed each time.
- Reset mid-operation: all state is cleared immediately. The memory side must also be reset, so no stale responses arrive.
- Counter widths:
  - count: clog2(DEPTH)+1 bits.
  - outstanding and drop_cnt: clog2(MAX_OUTSTANDING)+1 bits.
  - Pointers wrap mod DEPTH.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined:
  - When the queue is empty, drop_cnt == 0, iresp_valid=1 and redirect=0, the response is driven combinationally onto instr/instr_pc with instr_valid=1 in the same cycle.
  - If instr_ready=1 it is consumed without entering the queue; otherwise it is enqueued normally.
  - Response-to-decode latency is 0 cycles.
- Undefined: every response goes through the queue, with 1-cycle latency. This is the default timing.

Decomposition:
- Package fetch_pkg holds:
  - XLEN = 32 and PC_STEP = 4.
  - The fetch entry typedef {pc[31:0], instr[31:0]}.
  - NOP_INSTR = 32'hE1A0_0000.
- Sub-module fetch_fifo: a synchronous DEPTH-entry FIFO with flush, push/pop, count and head outputs. It carries the queue storage; the parent holds the PC, credit and drop logic.

Test Plan:
- Reset release, memory with ireq_ready=1 and fixed 1-cycle response → ireq_addr 0x0, 0x4, 0x8… accepted; instr_pc 0x0, 0x4, 0x8… in order, each instr matching memory.
- instr_ready=0 for 20 cycles with DEPTH=4, MAX_OUTSTANDING=2 → count saturates at 4, ireq_valid deasserts, no entry lost or duplicated; on release, PCs 0x0..0xC drain in order.
- Redirect to 0x100 while 2 responses are outstanding → those 2 words are discarded, the queue is empty next cycle, the next ireq_addr is 0x100, and the next instr_pc is 0x100.
- Redirect coincident with iresp_valid, plus a second redirect to 0x200 one cycle later → no stale instr presented; the first delivered instr_pc is 0x200.
- ireq_ready held 0 for 5 cycles → ireq_addr stays stable, fetch_pc does not advance, and outstanding does not change.
- Reset asserted mid-stream with a full queue → instr_valid=0 and ireq_addr=RESET_PC immediately (asynchronous), and fetch restarts at RESET_PC. With FETCH_BYPASS_EN and an empty queue, instr_valid is observed in the same cycle as iresp_valid.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants, entry type and PC helper for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PC_STEP = 4;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'hE1A0_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Force word alignment of a fetch address.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bus bundle: memory request/response, decode handshake and redirect.
interface fetch_prefetch_queue_if;
  import fetch_pkg::*;

  logic            ireq_valid;
  logic [XLEN-1:0] ireq_addr;
  logic            ireq_ready;
  logic            iresp_valid;
  logic [XLEN-1:0] iresp_data;
  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_ready;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output ireq_valid, ireq_addr, instr_valid, instr, instr_pc,
    input  ireq_ready, iresp_valid, iresp_data, instr_ready, redirect, redirect_pc
  );

  modport slave (
    input  ireq_valid, ireq_addr, instr_valid, instr, instr_pc,
    output ireq_ready, iresp_valid, iresp_data, instr_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush; head is read straight from storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output fetch_entry_t             head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  fetch_entry_t  mem_q [DEPTH];
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: it is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: sequential PC generation, credit-limited requests, in-order response
// queue and redirect flush. Optional macro FETCH_BYPASS_EN enables zero-latency response bypass.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000
) (
  input logic                    clk,
  input logic                    reset,
  fetch_prefetch_queue_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned SW = ((CW > OW) ? CW : OW) + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [OW-1:0]   out_q, out_d;
  logic [OW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   count;
  logic [SW-1:0]   in_flight;
  fetch_entry_t    head, head_sel, resp_entry, last_q;
  logic            fifo_empty, req_ok, req_acc, resp_keep, byp, byp_take, push, pop;

  assign fifo_empty = (count == '0);
  assign resp_entry = '{pc: resp_pc_q, instr: bus.iresp_data};
  assign resp_keep  = bus.iresp_valid && (drop_q == '0) && !bus.redirect;

  // Credit: queued + live (non-dropped) in-flight words never exceed the queue.
  assign in_flight = SW'(count) + SW'(out_q) - SW'(drop_q);
  assign req_ok    = reset && !bus.redirect && (out_q < OW'(MAX_OUTSTANDING))
                     && (in_flight < SW'(DEPTH));
  assign req_acc   = req_ok && bus.ireq_ready;

`ifdef FETCH_BYPASS_EN
  assign byp = reset && fifo_empty && resp_keep;
`else
  assign byp = 1'b0;
`endif
  assign byp_take = byp && bus.instr_ready;
  assign push     = resp_keep && !byp_take;
  assign pop      = !fifo_empty && bus.instr_ready && !bus.redirect;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .flush_i     (bus.redirect),
    .push_i      (push),
    .push_data_i (resp_entry),
    .pop_i       (pop),
    .count_o     (count),
    .head_o      (head)
  );

  // Presented entry; last_q keeps the outputs steady once the queue runs dry.
  always_comb begin
    head_sel = last_q;
    if (!fifo_empty) head_sel = head;
    else if (byp)    head_sel = resp_entry;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    out_d      = out_q + OW'(req_acc) - OW'(bus.iresp_valid);
    if (req_acc)   fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
    if (resp_keep) resp_pc_d  = resp_pc_q + XLEN'(PC_STEP);
    if (bus.redirect) begin
      fetch_pc_d = align_pc(bus.redirect_pc);
      resp_pc_d  = align_pc(bus.redirect_pc);
      drop_d     = out_d;
    end else if (bus.iresp_valid && (drop_q != '0)) begin
      drop_d = drop_q - OW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      last_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      last_q     <= head_sel;
    end
  end

  assign bus.ireq_valid  = req_ok;
  assign bus.ireq_addr   = fetch_pc_q;
  assign bus.instr_valid = !fifo_empty || byp;
  assign bus.instr       = head_sel.instr;
  assign bus.instr_pc    = head_sel.pc;

endmodule
